// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx core among NREQ requesters,
// with burst locking of up to BURST consecutive bytes per grant.
module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int         PW      = $clog2(NREQ);
    localparam logic [7:0] BURST_L = 8'(BURST);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   own, own_n;
    logic [PW-1:0]   pick;
    logic            found;
    logic [7:0]      count, count_n;
    logic [7:0]      tx_data_n;
    logic [NREQ-1:0] gnt_n, ack_n;
    logic            tx_start_n;
    logic [7:0]      bytes [NREQ];

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NREQ);
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_bytes
        assign bytes[i] = data[8*i +: 8];
    end

    // First pending requester searching circularly from ptr
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[wrap(int'(ptr) + k)]) begin
                found = 1'b1;
                pick  = wrap(int'(ptr) + k);
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        own_n      = own;
        count_n    = count;
        tx_data_n  = tx_data;
        gnt_n      = gnt;
        ack_n      = '0;
        tx_start_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_ready && found) begin
                    state_n    = SEND;
                    own_n      = pick;
                    gnt_n      = NREQ'(1) << pick;
                    ack_n      = NREQ'(1) << pick;
                    tx_data_n  = bytes[pick];
                    count_n    = 8'd1;
                    tx_start_n = 1'b1;
                end
            end
            SEND: begin
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    // Owner keeps the grant while it still has bytes and burst budget
                    if (req[own] && count < BURST_L) begin
                        state_n    = SEND;
                        tx_data_n  = bytes[own];
                        count_n    = count + 8'd1;
                        ack_n      = gnt;
                        tx_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        ptr_n   = wrap(int'(own) + 1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            own      <= '0;
            count    <= '0;
            tx_data  <= '0;
            gnt      <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            own      <= own_n;
            count    <= count_n;
            tx_data  <= tx_data_n;
            gnt      <= gnt_n;
            ack      <= ack_n;
            tx_start <= tx_start_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: byte queues per requester,
// a transaction-level round-robin model and a tx core model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic [31:0] data;
    logic       tx_ready;
    logic       sel;

    logic [3:0] ack_a, gnt_a, ack_b, gnt_b;
    logic       st_a, st_b, busy_a, busy_b;
    logic [7:0] td_a, td_b;

    logic [3:0] ack, gnt;
    logic       tx_start, busy;
    logic [7:0] tx_data;

    assign ack      = sel ? ack_b  : ack_a;
    assign gnt      = sel ? gnt_b  : gnt_a;
    assign tx_start = sel ? st_b   : st_a;
    assign busy     = sel ? busy_b : busy_a;
    assign tx_data  = sel ? td_b   : td_a;

    uart_tx_arbiter #(.NREQ(4), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .ack(ack_a), .gnt(gnt_a), .tx_start(st_a),
        .tx_data(td_a), .tx_ready(tx_ready), .busy(busy_a)
    );

    uart_tx_arbiter #(.NREQ(4), .BURST(1)) dut_b1 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .ack(ack_b), .gnt(gnt_b), .tx_start(st_b),
        .tx_data(td_b), .tx_ready(tx_ready), .busy(busy_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester byte queues and expected (requester, byte) order
    logic [7:0] rq [4][$];
    int         exp_id [$];
    logic [7:0] exp_byte [$];
    int         mptr = 0;
    int         burst_m = 4;

    function automatic void drive();
        logic [7:0] d [4];
        for (int i = 0; i < 4; i++) begin
            req[i] = (rq[i].size() != 0);
            d[i]   = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
        end
        data = {d[3], d[2], d[1], d[0]};
    endfunction

    function automatic void plan();
        logic [7:0] cq [4][$];
        int g, n;
        bit any;
        for (int i = 0; i < 4; i++) cq[i] = rq[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            g = 0;
            for (int k = 0; k < 4; k++) begin
                if (!any && cq[(mptr + k) % 4].size() != 0) begin
                    any = 1'b1;
                    g = (mptr + k) % 4;
                end
            end
            if (any) begin
                n = 0;
                while (n < burst_m && cq[g].size() != 0) begin
                    exp_id.push_back(g);
                    exp_byte.push_back(cq[g].pop_front());
                    n++;
                end
                mptr = (g + 1) % 4;
            end
        end
    endfunction

    // Monitor, requesters and tx core model, all at the falling edge
    int         cyc = 0, n_start = 0, last_start_cyc = 0;
    int         zrun = 0, last_gap = 0;
    logic       prev_start = 1'b0;
    logic [3:0] fl_gnt = '0;
    int         ph = 0, cnt = 0, blen = 10;
    logic       mready = 1'b1, hold = 1'b0;
    int         e_id;
    logic [7:0] e_b;

    always @(negedge clk) begin
        cyc++;
        if (gnt == 4'd0) zrun++;
        else begin
            if (zrun > 0) last_gap = zrun;
            zrun = 0;
            chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        end
        if (tx_start) begin
            n_start++;
            last_start_cyc = cyc;
            chk("start_pulse", 32'(prev_start), 32'd0);
            chk("pending_expect", 32'(exp_id.size() > 0), 32'd1);
            if (exp_id.size() > 0) begin
                e_id = exp_id.pop_front();
                e_b  = exp_byte.pop_front();
                fl_gnt = 4'(1 << e_id);
                chk("ack", 32'(ack), 32'(fl_gnt));
                chk("gnt", 32'(gnt), 32'(fl_gnt));
                chk("tx_data", 32'(tx_data), 32'(e_b));
            end
        end else if (ack != 4'd0) begin
            chk("ack_without_start", 32'(ack), 32'd0);
        end
        prev_start = tx_start;
        for (int i = 0; i < 4; i++)
            if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        drive();
        case (ph)
            0: if (tx_start) ph = 1;
            1: begin
                mready = 1'b0;
                cnt = blen;
                ph = 2;
            end
            default: begin
                cnt--;
                if (cnt == 0) begin
                    mready = 1'b1;
                    ph = 0;
                    chk("gnt_hold", 32'(gnt), 32'(fl_gnt));
                end
            end
        endcase
        tx_ready = mready & ~hold;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mptr = 0;
        exp_id.delete();
        exp_byte.delete();
        fl_gnt = '0;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        int left = 0;
        while ((exp_id.size() != 0 || ph != 0 || busy) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_done", 32'(k < budget), 32'd1);
        for (int i = 0; i < 4; i++) left += rq[i].size();
        chk("queues_empty", 32'(left), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        tick(1);
    endtask

    task automatic load_random();
        int n;
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            n = $urandom_range(0, 6);
            repeat (n) rq[i].push_back(8'($urandom));
        end
        blen = $urandom_range(2, 8);
        plan();
        drive();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t beyond limit %0t", $time, 5_000_000);
        $fatal(1);
    end

    initial begin
        int s0, k, load_cyc;
        rst = 1'b1;
        req = '0;
        data = '0;
        tx_ready = 1'b1;
        sel = 1'b0;
        tick(2);
        do_reset();

        // Single byte from requester 0: latency and grant hold
        blen = 10;
        rq[0].push_back(8'h41);
        plan();
        drive();
        load_cyc = cyc;
        drain(500);
        chk("latency", 32'(last_start_cyc - load_cyc), 32'd2);

        // Pointer moved to 1: requester 1 wins over 0
        rq[0].push_back(8'h11);
        rq[1].push_back(8'h22);
        plan();
        drive();
        drain(500);

        // Full contention, BURST=4
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 5; j++) rq[i].push_back(8'(16 * i + j));
        plan();
        drive();
        drain(3000);

        // "OK\n" from requester 1, then requester 3
        do_reset();
        rq[1].push_back(8'h4F);
        rq[1].push_back(8'h4B);
        rq[1].push_back(8'h0A);
        rq[3].push_back(8'h33);
        rq[3].push_back(8'h34);
        plan();
        drive();
        drain(1000);
        chk("handover_gap", 32'(last_gap <= 1), 32'd1);

        // tx core busy at reset release
        hold = 1'b1;
        do_reset();
        rq[1].push_back(8'h5A);
        plan();
        drive();
        s0 = n_start;
        tick(15);
        chk("no_start_not_ready", 32'(n_start - s0), 32'd0);
        chk("busy_not_ready", 32'(busy), 32'd0);
        hold = 1'b0;
        drain(500);

        // Reset while waiting for the tx core to finish
        do_reset();
        blen = 10;
        rq[0] = '{8'h01, 8'h02, 8'h03};
        rq[1] = '{8'h04, 8'h05};
        plan();
        drive();
        k = 0;
        while (ph != 2 && k < 300) begin
            tick(1);
            k++;
        end
        chk("wait_done_reached", 32'(ph), 32'd2);
        do_reset();
        plan();
        drain(1000);

        for (int s = 0; s < 30; s++) begin
            load_random();
            drain(3000);
        end

        // BURST=1 instance
        sel = 1'b1;
        burst_m = 1;
        do_reset();
        blen = 10;
        rq[0] = '{8'hA0, 8'hA1, 8'hA2};
        rq[2] = '{8'hC0, 8'hC1, 8'hC2};
        plan();
        drive();
        drain(1000);
        for (int s = 0; s < 10; s++) begin
            load_random();
            drain(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
